spi_mem_responder: RTL

//  Synthesisable SPI mode-0 target modelling a small serial NOR memory: the far end of the
//  SPI initiator driving SPI_CLK/SPI_MOSI/SPI_CS_n. Oversamples the bus on CLKA, decodes

---
 rtl/spi_mem_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target modelling a small serial NOR memory (read, status, ID, page program).
// Bus inputs are 2-FF synchronised to CLKA and edge-detected; all outputs are registered.
module spi_mem_responder #(
   parameter int          ADDR_W      = 8,
   parameter int          PROG_CYCLES = 1000,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
   input  logic       CLKA,
   input  logic       RST,
   input  logic       SPI_CLK,
   input  logic       SPI_CS_n,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   output logic       MISO_OE,
   output logic       CMD_STROBE,
   output logic [7:0] CMD_BYTE,
   output logic       WIP
);

   localparam int TMR_W = $clog2(PROG_CYCLES + 1);

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PROG = 8'h02;
   localparam logic [7:0] OP_STAT = 8'h05;
   localparam logic [7:0] OP_ID   = 8'h9F;
   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_WRDI = 8'h04;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_STAT, S_ID, S_IGNORE
   } state_t;

   state_t              r_state;
   logic [2:0]          r_sck_sync;
   logic [2:0]          r_cs_sync;
   logic [1:0]          r_mosi_sync;
   logic [2:0]          r_bit_cnt;
   logic [1:0]          r_idx;
   logic [6:0]          r_shift;
   logic [7:0]          r_tx;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_wel;
   logic                r_prog_any;
   logic                r_wr_pend;
   logic [7:0]          r_wr_dat;
   logic [TMR_W-1:0]    r_tmr;
   logic [7:0]          r_mem [2**ADDR_W];

   logic                w_sck_rise;
   logic                w_sck_fall;
   logic                w_cs_rise;
   logic                w_cs_fall;
   logic                w_cs_act;
   logic                w_mosi;
   logic                w_byte_done;
   logic                w_resp_state;
   logic [7:0]          w_rx_byte;
   logic [7:0]          w_tx_byte;

   always_ff @(posedge CLKA) begin
      if (RST) begin
         r_sck_sync  <= 3'b000;
         r_cs_sync   <= 3'b111;
         r_mosi_sync <= 2'b00;
      end else begin
         r_sck_sync  <= {r_sck_sync[1:0], SPI_CLK};
         r_cs_sync   <= {r_cs_sync[1:0], SPI_CS_n};
         r_mosi_sync <= {r_mosi_sync[0], SPI_MOSI};
      end
   end

   assign w_sck_rise   =  r_sck_sync[1] & ~r_sck_sync[2];
   assign w_sck_fall   = ~r_sck_sync[1] &  r_sck_sync[2];
   assign w_cs_rise    =  r_cs_sync[1]  & ~r_cs_sync[2];
   assign w_cs_fall    = ~r_cs_sync[1]  &  r_cs_sync[2];
   assign w_cs_act     = ~r_cs_sync[1];
   assign w_mosi       =  r_mosi_sync[1];
   assign w_byte_done  = (r_bit_cnt == 3'd7);
   assign w_rx_byte    = {r_shift, w_mosi};
   assign w_resp_state = (r_state == S_READ) || (r_state == S_STAT) || (r_state == S_ID);

   // Byte loaded onto MISO at each byte start (bit counter back at 0 on the SCK fall)
   always_comb begin
      w_tx_byte = 8'h00;
      case (r_state)
         S_READ: w_tx_byte = r_mem[r_addr];
         S_STAT: w_tx_byte = {6'b0, r_wel, WIP};
         S_ID: begin
            case (r_idx)
               2'd0:    w_tx_byte = JEDEC_ID[23:16];
               2'd1:    w_tx_byte = JEDEC_ID[15:8];
               2'd2:    w_tx_byte = JEDEC_ID[7:0];
               default: w_tx_byte = 8'h00;
            endcase
         end
         default: w_tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge CLKA) begin
      if (RST) begin
         r_state    <= S_IDLE;
         SPI_MISO   <= 1'b0;
         MISO_OE    <= 1'b0;
         CMD_STROBE <= 1'b0;
         CMD_BYTE   <= 8'h00;
         WIP        <= 1'b0;
         r_wel      <= 1'b0;
         r_bit_cnt  <= 3'd0;
         r_idx      <= 2'd0;
         r_shift    <= 7'd0;
         r_tx       <= 8'h00;
         r_addr     <= '0;
         r_prog_any <= 1'b0;
         r_wr_pend  <= 1'b0;
         r_wr_dat   <= 8'h00;
         r_tmr      <= '0;
      end else begin
         CMD_STROBE <= 1'b0;
         if (r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
            if (r_tmr == TMR_W'(1))
               WIP <= 1'b0;
         end
         if (r_wr_pend) begin
            r_wr_pend <= 1'b0;
            r_addr    <= r_addr + ADDR_W'(1);
         end
         if (w_cs_rise) begin
            r_state   <= S_IDLE;
            MISO_OE   <= 1'b0;
            SPI_MISO  <= 1'b0;
            r_bit_cnt <= 3'd0;
            if (r_state == S_PROG && r_prog_any) begin
               r_wel <= 1'b0;
               WIP   <= 1'b1;
               r_tmr <= TMR_W'(PROG_CYCLES);
            end
         end else if (w_cs_fall) begin
            r_state    <= S_CMD;
            r_bit_cnt  <= 3'd0;
            r_idx      <= 2'd0;
            r_prog_any <= 1'b0;
         end else if (w_cs_act && r_state != S_IDLE) begin
            if (w_sck_rise) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               r_shift   <= w_rx_byte[6:0];
               if (r_state == S_ADDR)
                  r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
               if (w_byte_done) begin
                  case (r_state)
                     S_CMD: begin
                        CMD_STROBE <= 1'b1;
                        CMD_BYTE   <= w_rx_byte;
                        r_idx      <= 2'd0;
                        case (w_rx_byte)
                           OP_READ, OP_PROG: r_state <= S_ADDR;
                           OP_STAT:          r_state <= S_STAT;
                           OP_ID:            r_state <= S_ID;
                           OP_WREN: begin
                              r_state <= S_IGNORE;
                              if (!WIP)
                                 r_wel <= 1'b1;
                           end
                           OP_WRDI: begin
                              r_state <= S_IGNORE;
                              r_wel   <= 1'b0;
                           end
                           default:          r_state <= S_IGNORE;
                        endcase
                     end
                     S_ADDR: begin
                        if (r_idx == 2'd2) begin
                           r_idx <= 2'd0;
                           if (CMD_BYTE == OP_READ)
                              r_state <= S_READ;
                           else if (r_wel && !WIP)
                              r_state <= S_PROG;
                           else
                              r_state <= S_IGNORE;
                        end else begin
                           r_idx <= r_idx + 2'd1;
                        end
                     end
                     S_READ: r_addr <= r_addr + ADDR_W'(1);
                     S_PROG: begin
                        r_wr_pend  <= 1'b1;
                        r_wr_dat   <= w_rx_byte;
                        r_prog_any <= 1'b1;
                     end
                     S_ID: begin
                        if (r_idx != 2'd3)
                           r_idx <= r_idx + 2'd1;
                     end
                     default: ;
                  endcase
               end
            end else if (w_sck_fall && w_resp_state) begin
               MISO_OE <= 1'b1;
               if (r_bit_cnt == 3'd0) begin
                  SPI_MISO <= w_tx_byte[7];
                  r_tx     <= {w_tx_byte[6:0], 1'b0};
               end else begin
                  SPI_MISO <= r_tx[7];
                  r_tx     <= {r_tx[6:0], 1'b0};
               end
            end
         end
      end
   end

   // Array is deliberately not reset; a byte still pending when RST arrives is dropped
   always_ff @(posedge CLKA) begin
      if (r_wr_pend && !RST)
         r_mem[r_addr] <= r_wr_dat;
   end

endmodule
